// File: rtl/dm_arbiter_if.sv
// Data-memory arbiter bus: CPU and auxiliary request ports plus the shared DM port.
// The arbiter uses the slave modport; requesters and the memory side use master.
interface dm_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic        cpu_rvalid;

    logic        aux_req;
    logic        aux_we;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic        aux_lock;
    logic        aux_gnt;
    logic        aux_rvalid;

    logic [31:0] rdata;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  aux_req, aux_we, aux_addr, aux_wdata, aux_lock,
        input  dm_rdata,
        output cpu_gnt, cpu_stall, cpu_rvalid,
        output aux_gnt, aux_rvalid,
        output rdata, dm_we, dm_addr, dm_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output aux_req, aux_we, aux_addr, aux_wdata, aux_lock,
        output dm_rdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid,
        input  aux_gnt, aux_rvalid,
        input  rdata, dm_we, dm_addr, dm_wdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU Mem stage and an auxiliary loader/DMA port.
// Define DM_ARB_PERF_EN to add the saturating stall/transfer performance counters.
//
// state | meaning
// RR    | round-robin: sole requester wins, on contention the port not in last_q wins
// LOCK  | aux holds DM for a locked burst of up to BURST_MAX consecutive grants
module dm_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    dm_arbiter_if.slave        bus
`ifdef DM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_cpu_stall,
    output logic [31:0]        perf_aux_xfer
`endif
);

    typedef enum logic {
        RR   = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic       PORT_CPU = 1'b0;
    localparam logic       PORT_AUX = 1'b1;
    localparam logic [3:0] CNT_MAX  = 4'(BURST_MAX);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        cpu_rvalid_q, aux_rvalid_q;

    logic        cpu_gnt, aux_gnt, cpu_stall;
    logic        lock_cont;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RR;
            cnt_q        <= '0;
            last_q       <= PORT_AUX;
            cpu_rvalid_q <= 1'b0;
            aux_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            cpu_rvalid_q <= cpu_gnt & ~bus.cpu_we;
            aux_rvalid_q <= aux_gnt & ~bus.aux_we;
        end
    end

    // When a burst cannot continue, the same cycle falls back to round-robin,
    // so a CPU waiting behind a capped burst is granted immediately.
    always_comb begin
        lock_cont = (state_q == LOCK) && bus.aux_req && bus.aux_lock && (cnt_q < CNT_MAX);

        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (lock_cont) begin
            aux_gnt = 1'b1;
        end else if (bus.cpu_req && bus.aux_req) begin
            if (last_q == PORT_AUX) begin
                cpu_gnt = 1'b1;
            end else begin
                aux_gnt = 1'b1;
            end
        end else if (bus.cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (bus.aux_req) begin
            aux_gnt = 1'b1;
        end

        last_d = last_q;
        if (cpu_gnt) begin
            last_d = PORT_CPU;
        end
        if (aux_gnt) begin
            last_d = PORT_AUX;
        end

        state_d = RR;
        cnt_d   = '0;
        if (lock_cont) begin
            state_d = LOCK;
            cnt_d   = cnt_q + 4'd1;
        end else if (aux_gnt && bus.aux_lock) begin
            state_d = LOCK;
            cnt_d   = 4'd1;
        end
    end

    always_comb begin
        bus.dm_we    = 1'b0;
        bus.dm_addr  = bus.cpu_addr;
        bus.dm_wdata = bus.cpu_wdata;
        if (aux_gnt) begin
            bus.dm_we    = bus.aux_we;
            bus.dm_addr  = bus.aux_addr;
            bus.dm_wdata = bus.aux_wdata;
        end else if (cpu_gnt) begin
            bus.dm_we    = bus.cpu_we;
        end
    end

    assign cpu_stall      = bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.aux_gnt    = aux_gnt;
    assign bus.cpu_stall  = cpu_stall;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.aux_rvalid = aux_rvalid_q;
    assign bus.rdata      = bus.dm_rdata;

`ifdef DM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cpu_stall <= '0;
            perf_aux_xfer  <= '0;
        end else begin
            if (cpu_stall && (perf_cpu_stall != 32'hFFFF_FFFF)) begin
                perf_cpu_stall <= perf_cpu_stall + 32'd1;
            end
            if (aux_gnt && (perf_aux_xfer != 32'hFFFF_FFFF)) begin
                perf_aux_xfer <= perf_aux_xfer + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4, meaning the maximum consecutive locked aux grants (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cpu_req  input  1  Mem-stage DM access request.
REQ-005 SHALL have port cpu_we  input  1  CPU write (1) / read (0).
REQ-006 SHALL have port cpu_addr  input  32  CPU byte address (ALU result).
REQ-007 SHALL have port cpu_wdata  input  32  CPU store data (post-bypass).
REQ-008 SHALL have port cpu_gnt  output  1  CPU owns DM this cycle.
REQ-009 SHALL have port cpu_stall  output  1  cpu_req & ~cpu_gnt, to the hazard unit.
REQ-010 SHALL have port cpu_rvalid  output  1  rdata holds the CPU read result.
REQ-011 SHALL have port aux_req  input  1  auxiliary (loader/DMA) request.
REQ-012 SHALL have port aux_we  input  1  aux write (1) / read (0).
REQ-013 SHALL have port aux_addr  input  32  aux byte address.
REQ-014 SHALL have port aux_wdata  input  32  aux write data.
REQ-015 SHALL have port aux_lock  input  1  aux requests a locked burst.
REQ-016 SHALL have port aux_gnt  output  1  aux owns DM this cycle.
REQ-017 SHALL have port aux_rvalid  output  1  rdata holds the aux read result.
REQ-018 SHALL have port rdata  output  32  shared read data, equal to dm_rdata.
REQ-019 SHALL have port dm_we  output  1  DM write enable.
REQ-020 SHALL have port dm_addr  output  32  DM address.
REQ-021 SHALL have port dm_wdata  output  32  DM write data.
REQ-022 SHALL have port dm_rdata  input  32  DM synchronous read data, valid 1 cycle after the address.

Function
REQ-023 SHALL implement the FSM states RR (round-robin) and LOCK.
REQ-024 SHALL, in RR, grant the sole requester; if both request, SHALL grant the port not recorded in register last; if neither requests, SHALL grant neither.
REQ-025 SHALL update last to the winner on every granted cycle and SHALL hold it otherwise.
REQ-026 SHALL compute grants combinationally in the same cycle as req; at most one grant SHALL be high per cycle.
REQ-027 SHALL drive dm_we/dm_addr/dm_wdata from the granted port; with no grant, dm_we=0 and dm_addr/dm_wdata=cpu_addr/cpu_wdata.
REQ-028 SHALL transition RR->LOCK on an aux grant with aux_lock=1, loading burst counter cnt=1.
REQ-029 SHALL, in LOCK, grant aux while aux_req&aux_lock and cnt<BURST_MAX, incrementing cnt each grant; cpu_stall SHALL stay high meanwhile.
REQ-030 SHALL return LOCK->RR when aux_req=0, aux_lock=0, or cnt reaches BURST_MAX, clearing cnt; on the cap exit, last=AUX so a waiting CPU wins next cycle.
REQ-031 SHALL register cpu_rvalid <= cpu_gnt&~cpu_we and aux_rvalid <= aux_gnt&~aux_we (1-cycle read latency); writes SHALL produce no rvalid.
REQ-032 SHALL pass addresses and data unmodified (no alignment checks).

Reset
REQ-033 SHALL, while reset=0 (asynchronously, including mid-burst), force state=RR, cnt=0, last=AUX, cpu_rvalid=0, aux_rvalid=0; grants SHALL then follow REQ-024 combinationally.
REQ-034 SHALL give the CPU priority on the first contended cycle after reset release.

Configuration
REQ-035 SHALL, with DM_ARB_PERF_EN defined, add outputs perf_cpu_stall[31:0] (counts cpu_stall cycles) and perf_aux_xfer[31:0] (counts aux grants), saturating at 32'hFFFF_FFFF and cleared by reset.
REQ-036 SHALL, without DM_ARB_PERF_EN, omit both counters and ports; all other behaviour SHALL be identical.

Verification
REQ-037 SHALL test: cpu_req=1 only, cpu_we=0, cpu_addr=0x10 -> cpu_gnt=1, dm_addr=0x10, cpu_rvalid=1 next cycle, rdata=dm_rdata.
REQ-038 SHALL test: both req held 4 cycles, no lock, after reset -> grant sequence CPU,AUX,CPU,AUX; cpu_stall=0,1,0,1.
REQ-039 SHALL test: aux_lock=1, both req held 7 cycles, BURST_MAX=4 -> AUX x4, CPU, AUX x2 (new lock); cpu_stall high for the first 4 cycles.
REQ-040 SHALL test: aux write aux_addr=0x20, aux_wdata=0xDEADBEEF -> dm_we=1, dm_wdata=0xDEADBEEF, aux_rvalid stays 0.
REQ-041 SHALL test: reset asserted at cnt=2 in LOCK -> state RR, cnt=0, rvalids 0 immediately; CPU wins the first contended cycle after release.
REQ-042 SHALL test (DM_ARB_PERF_EN): REQ-039 stimulus -> perf_cpu_stall=6, perf_aux_xfer=6.
